// File: rtl/rd_track.sv
// rd_track: EX/MEM/WB register-id tracker with load-use stall detection.
// Exposes the pipeline register fields that the forwarding and hazard logic need.
module rd_track #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_uses_rt,
  input  logic             flush_i,
  output logic [4:0]       ExeRs,
  output logic [4:0]       ExeRt,
  output logic [4:0]       MemRd,
  output logic             MemWb,
  output logic [4:0]       WbRd,
  output logic             Wb,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;
  logic [4:0]       r_ex_dst;
  logic             r_ex_rw;
  logic             r_ex_mr;
  logic [4:0]       r_mem_dst;
  logic             r_mem_rw;
  logic [4:0]       r_wb_dst;
  logic             r_wb_rw;
  logic [CNT_W-1:0] r_cnt;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_stall;
  logic w_bubble;
  logic w_cnt_max;

  // Load in EX whose destination feeds the ID instruction.
  always_comb begin
    w_rs_hit  = (r_ex_dst == id_rs);
    w_rt_hit  = id_uses_rt && (r_ex_dst == id_rt);
    w_stall   = r_ex_mr && (r_ex_dst != 5'd0) &&
                !flush_i && (w_rs_hit || w_rt_hit);
    w_bubble  = flush_i || w_stall;
    w_cnt_max = &r_cnt;
  end

  // EX slot: bubble on flush or stall, else capture the ID fields.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_bubble) begin
      r_ex_rs  <= 5'd0;
      r_ex_rt  <= 5'd0;
      r_ex_dst <= 5'd0;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
    end else begin
      r_ex_rs  <= id_rs;
      r_ex_rt  <= id_rt;
      r_ex_dst <= id_dst;
      r_ex_rw  <= id_regwrite;
      r_ex_mr  <= id_memread;
    end
  end

  // MEM and WB slots always advance; stalls never freeze them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_dst <= 5'd0;
      r_mem_rw  <= 1'b0;
      r_wb_dst  <= 5'd0;
      r_wb_rw   <= 1'b0;
    end else begin
      r_mem_dst <= r_ex_dst;
      r_mem_rw  <= r_ex_rw;
      r_wb_dst  <= r_mem_dst;
      r_wb_rw   <= r_mem_rw;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_stall && !w_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ExeRs     = r_ex_rs;
  assign ExeRt     = r_ex_rt;
  assign MemRd     = r_mem_dst;
  assign MemWb     = r_mem_rw;
  assign WbRd      = r_wb_dst;
  assign Wb        = r_wb_rw;
  assign stall_o   = w_stall;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_rd_track.sv
// tb_rd_track: directed and random checks of rd_track against a
// slot-level reference model; a CNT_W=2 copy checks saturation.
module tb_rd_track;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_regwrite, id_memread, id_uses_rt, flush_i;

  logic [4:0]  ExeRs, ExeRt, MemRd, WbRd;
  logic        MemWb, Wb, stall_o;
  logic [15:0] stall_cnt;

  logic [4:0]  s_ExeRs, s_ExeRt, s_MemRd, s_WbRd;
  logic        s_MemWb, s_Wb, s_stall;
  logic [1:0]  s_cnt;

  always #5 clk_i = ~clk_i;

  rd_track #(.CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_uses_rt(id_uses_rt), .flush_i(flush_i),
    .ExeRs(ExeRs), .ExeRt(ExeRt), .MemRd(MemRd),
    .MemWb(MemWb), .WbRd(WbRd), .Wb(Wb),
    .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  rd_track #(.CNT_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_uses_rt(id_uses_rt), .flush_i(flush_i),
    .ExeRs(s_ExeRs), .ExeRt(s_ExeRt), .MemRd(s_MemRd),
    .MemWb(s_MemWb), .WbRd(s_WbRd), .Wb(s_Wb),
    .stall_o(s_stall), .stall_cnt(s_cnt)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  int    m_cnt, m_cnt2;
  logic  m_stall;
  logic  obs_stall, obs_stall2;
  int    checks = 0;
  int    errors = 0;

  function automatic slot_t bubble();
    slot_t b;
    b.rs = 0; b.rt = 0; b.dst = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  // One clock: apply ID inputs, sample stall_o, advance the model.
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] dst, input logic rw,
                     input logic mr, input logic ut,
                     input logic fl, input logic rst);
    slot_t nid;
    logic  haz;
    @(negedge clk_i);
    id_rs = rs; id_rt = rt; id_dst = dst;
    id_regwrite = rw; id_memread = mr;
    id_uses_rt = ut; flush_i = fl; rst_i = rst;
    #1;
    obs_stall  = stall_o;
    obs_stall2 = s_stall;
    haz = (m_ex.dst == rs) || (ut && m_ex.dst == rt);
    m_stall = m_ex.mr && m_ex.dst != 0 && !fl && haz;
    @(posedge clk_i);
    if (rst) begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      nid.rs = rs; nid.rt = rt; nid.dst = dst;
      nid.rw = rw; nid.mr = mr;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (fl || m_stall) ? bubble() : nid;
      if (m_stall) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      end
    end
    #1;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drv(5'd7, 5'd9, 5'd3, 1, 1, 1, 0, 1);
    checks++;
    if ({ExeRs, ExeRt, MemRd, MemWb, WbRd, Wb} !== 23'd0) begin
      errors++;
      $display("FAIL reset_slots got %h want 0",
               {ExeRs, ExeRt, MemRd, MemWb, WbRd, Wb});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    drv(5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_nostall got %b want 0", obs_stall);
    end
  endtask

  task automatic test_flow();
    drv(5'd1, 5'd2, 5'd5, 1, 0, 1, 0, 0);
    checks++;
    if ({ExeRs, ExeRt} !== {5'd1, 5'd2}) begin
      errors++;
      $display("FAIL flow_ex got %0d/%0d want 1/2", ExeRs, ExeRt);
    end
    nop();
    checks++;
    if ({MemRd, MemWb} !== {5'd5, 1'b1}) begin
      errors++;
      $display("FAIL flow_mem got %0d/%b want 5/1", MemRd, MemWb);
    end
    nop();
    checks++;
    if ({WbRd, Wb} !== {5'd5, 1'b1}) begin
      errors++;
      $display("FAIL flow_wb got %0d/%b want 5/1", WbRd, Wb);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = int'(stall_cnt);
    drv(5'd3, 5'd0, 5'd8, 1, 1, 0, 0, 0);
    drv(5'd8, 5'd4, 5'd10, 1, 0, 1, 0, 0);
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", obs_stall);
    end
    checks++;
    if ({ExeRs, ExeRt, MemRd} !== {5'd0, 5'd0, 5'd8}) begin
      errors++;
      $display("FAIL lu_bubble got %0d/%0d/%0d want 0/0/8",
               ExeRs, ExeRt, MemRd);
    end
    checks++;
    if (int'(stall_cnt) !== c0 + 1) begin
      errors++;
      $display("FAIL lu_cnt got %0d want %0d", stall_cnt, c0 + 1);
    end
    drv(5'd8, 5'd4, 5'd10, 1, 0, 1, 0, 0);
    checks++;
    if (obs_stall !== 1'b0 || ExeRs !== 5'd8) begin
      errors++;
      $display("FAIL lu_replay got %b/%0d want 0/8", obs_stall, ExeRs);
    end
  endtask

  task automatic test_rt_gate();
    drv(5'd1, 5'd0, 5'd9, 1, 1, 0, 0, 0);
    drv(5'd2, 5'd9, 5'd11, 1, 0, 0, 0, 0);
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++;
      $display("FAIL rt_gated got %b want 0", obs_stall);
    end
    drv(5'd1, 5'd0, 5'd9, 1, 1, 0, 0, 0);
    drv(5'd2, 5'd9, 5'd11, 1, 0, 1, 0, 0);
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++;
      $display("FAIL rt_used got %b want 1", obs_stall);
    end
    drv(5'd2, 5'd9, 5'd11, 1, 0, 1, 0, 0);
  endtask

  task automatic test_flush();
    int c0;
    drv(5'd1, 5'd0, 5'd7, 1, 1, 0, 0, 0);
    c0 = int'(stall_cnt);
    drv(5'd7, 5'd0, 5'd12, 1, 0, 0, 1, 0);
    checks++;
    if (obs_stall !== 1'b0 || int'(stall_cnt) !== c0) begin
      errors++;
      $display("FAIL flush_prio got %b/%0d want 0/%0d",
               obs_stall, stall_cnt, c0);
    end
    checks++;
    if (ExeRs !== 5'd0) begin
      errors++;
      $display("FAIL flush_ex got %0d want 0", ExeRs);
    end
    nop();
    checks++;
    if (MemWb !== 1'b0) begin
      errors++;
      $display("FAIL flush_mem got %b want 0", MemWb);
    end
  endtask

  task automatic test_x0();
    drv(5'd1, 5'd0, 5'd0, 1, 1, 0, 0, 0);
    drv(5'd0, 5'd0, 5'd3, 1, 0, 1, 0, 0);
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_nostall got %b want 0", obs_stall);
    end
  endtask

  task automatic test_saturation();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drv(5'd1, 5'd0, 5'd6, 1, 1, 0, 0, 0);
      drv(5'd6, 5'd0, 5'd2, 1, 0, 0, 0, 0);
      drv(5'd6, 5'd0, 5'd2, 1, 0, 0, 0, 0);
    end
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt2 got %0d want 3", s_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_cnt16 got %0d want 5", stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drv(5'd1, 5'd0, 5'd4, 1, 1, 0, 0, 0);
    drv(5'd4, 5'd0, 5'd5, 1, 0, 0, 0, 0);
    drv(5'd4, 5'd0, 5'd5, 1, 0, 0, 0, 1);
    checks++;
    if ({MemRd, MemWb, WbRd, Wb} !== 12'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid got %h/%0d want 0/0",
               {MemRd, MemWb, WbRd, Wb}, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] rs, rt, dst;
    for (int i = 0; i < 400; i++) begin
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      dst = 5'($urandom_range(0, 3));
      drv(rs, rt, dst, 1'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 63) == 0));
      checks++;
      if (obs_stall !== m_stall || obs_stall2 !== m_stall) begin
        errors++;
        $display("FAIL rnd_stall i=%0d got %b/%b want %b",
                 i, obs_stall, obs_stall2, m_stall);
      end
      checks++;
      if ({ExeRs, ExeRt, MemRd, MemWb, WbRd, Wb} !==
          {m_ex.rs, m_ex.rt, m_mem.dst, m_mem.rw,
           m_wb.dst, m_wb.rw}) begin
        errors++;
        $display("FAIL rnd_slots i=%0d got %h want %h", i,
                 {ExeRs, ExeRt, MemRd, MemWb, WbRd, Wb},
                 {m_ex.rs, m_ex.rt, m_mem.dst, m_mem.rw,
                  m_wb.dst, m_wb.rw});
      end
      checks++;
      if (int'(stall_cnt) !== m_cnt || int'(s_cnt) !== m_cnt2) begin
        errors++;
        $display("FAIL rnd_cnt i=%0d got %0d/%0d want %0d/%0d",
                 i, stall_cnt, s_cnt, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_cnt = 0; m_cnt2 = 0; m_stall = 0;
    rst_i = 1; flush_i = 0;
    id_rs = 0; id_rt = 0; id_dst = 0;
    id_regwrite = 0; id_memread = 0; id_uses_rt = 0;
    test_reset();
    test_flow();
    test_load_use();
    test_rt_gate();
    test_flush();
    test_x0();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
